// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//
// Front-end receive stage of the UART controller. The asynchronous rxd line
// is synchronised, then oversampled at 16x baud using the tick16 enable.
// The block validates start bits, takes a majority vote of three mid-bit
// samples for every bit, assembles LSB-first frames and hands each good
// byte to the RX controller with a one-cycle strobe.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit, the PARITY_ODD parameter and the par_err port.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..8)
//   OVERSAMPLE  ticks per bit, fixed at 16 (tick counter is 4 bits)
//   PARITY_ODD  (UART_RX_PARITY_EN only) 0 = even parity, 1 = odd parity
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   tick16     one-clk enable at 16x baud; all bit timing advances on it
//   rxd        asynchronous serial input, idle high
//   dout       last correctly received byte, right-justified, upper bits 0
//   rx_rdy     one-clk pulse, new byte valid on dout
//   frame_err  one-clk pulse, stop bit sampled low
//   busy       high while a frame is in progress
//   par_err    (UART_RX_PARITY_EN only) one-clk pulse with rx_rdy when the
//              received parity bit does not match the data
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter logic PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick16,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       rx_rdy,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       par_err
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    // Tick positions inside one bit period: three votes around mid-bit,
    // the last of which also resolves the bit, and the end of the bit.
    localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] VOTE_A   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] VOTE_B   = 4'(OVERSAMPLE / 2);
    localparam logic [3:0] VOTE_C   = 4'(OVERSAMPLE / 2 + 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rxd_meta;
    logic                 rxd_s;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           cnt;
    logic [3:0]           cnt_nxt;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic                 vote_a;
    logic                 vote_a_nxt;
    logic                 vote_b;
    logic                 vote_b_nxt;
    logic                 majority;

    logic [7:0]           dout_nxt;
    logic                 rx_rdy_nxt;
    logic                 frame_err_nxt;

`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 par_bit_nxt;
    logic                 par_err_nxt;
`endif

    // Two-flop synchroniser; both flops reset to the idle level so that
    // leaving reset never looks like a falling start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // The third vote is the live synchronised sample, so the majority is
    // valid on the tick where cnt reaches VOTE_C.
    assign majority = (vote_a & vote_b) | (vote_a & rxd_s) | (vote_b & rxd_s);

    assign busy = (state != IDLE);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            bit_idx   <= 3'd0;
            shreg     <= '0;
            vote_a    <= 1'b0;
            vote_b    <= 1'b0;
            dout      <= 8'd0;
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            vote_a    <= vote_a_nxt;
            vote_b    <= vote_b_nxt;
            dout      <= dout_nxt;
            rx_rdy    <= rx_rdy_nxt;
            frame_err <= frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit   <= par_bit_nxt;
            par_err   <= par_err_nxt;
`endif
        end
    end

    // Next-state and strobe logic. Nothing moves without tick16, and the
    // strobes are cleared on every other cycle so they last exactly one clk.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        vote_a_nxt    = vote_a;
        vote_b_nxt    = vote_b;
        dout_nxt      = dout;
        rx_rdy_nxt    = 1'b0;
        frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt   = par_bit;
        par_err_nxt   = 1'b0;
`endif

        if (tick16) begin
            cnt_nxt = cnt + 4'd1;
            if (cnt == VOTE_A) begin
                vote_a_nxt = rxd_s;
            end
            if (cnt == VOTE_B) begin
                vote_b_nxt = rxd_s;
            end

            case (state)
                IDLE: begin
                    cnt_nxt = 4'd0;
                    if (!rxd_s) begin
                        state_nxt = START;
                    end
                end

                START: begin
                    if (cnt == VOTE_C && majority) begin
                        // Low pulse shorter than half a bit: noise, not a start.
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = 3'd0;
                    end
                end

                DATA: begin
                    if (cnt == VOTE_C) begin
                        // LSB arrives first, so shifting in at the top leaves
                        // the byte right-way-round after the last bit.
                        shreg_nxt = {majority, shreg[DATA_BITS-1:1]};
                    end
                    if (cnt == CNT_LAST) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end else begin
                            bit_idx_nxt = bit_idx + 3'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == VOTE_C) begin
                        par_bit_nxt = majority;
                    end
                    if (cnt == CNT_LAST) begin
                        state_nxt = STOP;
                    end
                end
`endif

                STOP: begin
                    if (cnt == VOTE_C) begin
                        // Leave at mid-stop so a start bit immediately
                        // following the stop bit is still caught.
                        cnt_nxt = 4'd0;
                        if (majority) begin
                            state_nxt                 = IDLE;
                            dout_nxt                  = 8'd0;
                            dout_nxt[DATA_BITS-1:0]   = shreg;
                            rx_rdy_nxt                = 1'b1;
`ifdef UART_RX_PARITY_EN
                            par_err_nxt = (((^shreg) ^ par_bit) != PARITY_ODD);
`endif
                        end else begin
                            state_nxt     = WAIT_IDLE;
                            frame_err_nxt = 1'b1;
                        end
                    end
                end

                WAIT_IDLE: begin
                    // A held-low line (break) must not re-trigger as frames.
                    cnt_nxt = 4'd0;
                    if (rxd_s) begin
                        state_nxt = IDLE;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_sampler
//
// Self-checking bench for uart_rx_sampler. The serial line is described as
// one sample per tick16 pulse. A behavioural receiver works directly on that
// sample list (start search, three-sample majority at fixed offsets from the
// detected start) and predicts the outputs after every tick; a compare
// process checks the DUT against that prediction on every clock, and
// checkpoints pin literal values for the directed scenarios.
// Build with UART_RX_PARITY_EN defined to exercise the parity option.
// ---------------------------------------------------------------------------
module tb_uart_rx_sampler;

    localparam int DATA_BITS = 8;
    localparam int MAXN      = 8000;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick16;
    logic       rxd;
    logic [7:0] dout;
    logic       rx_rdy;
    logic       frame_err;
    logic       busy;
    logic       par_err_w;

    uart_rx_sampler #(
        .DATA_BITS(DATA_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick16   (tick16),
        .rxd      (rxd),
        .dout     (dout),
        .rx_rdy   (rx_rdy),
        .frame_err(frame_err),
        .busy     (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .par_err  (par_err_w)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign par_err_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Line level per tick, and the predicted outputs after each tick.
    logic       line_q[$];
    logic       exp_rdy [MAXN];
    logic       exp_ferr[MAXN];
    logic       exp_perr[MAXN];
    logic       exp_busy[MAXN];
    logic [7:0] exp_dout[MAXN];
    logic [7:0] byte_at [MAXN];

    int cur_k    = -1;
    bit checking = 1'b0;

    int seen_k     = -1;
    int rdy_total  = 0;
    int ferr_total = 0;
    int perr_total = 0;

    typedef struct {
        int         k;
        logic [7:0] d;
        int         rdy;
        int         ferr;
        int         perr;
        logic       bsy;
    } cp_t;
    cp_t cps[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    // ---------------- line construction ----------------
    task automatic add_bits(input logic v, input int n);
        repeat (n) line_q.push_back(v);
    endtask

    task automatic add_frame(input logic [7:0] b, input logic stop_v, input logic par_good);
        logic p;
        add_bits(1'b0, 16);
        for (int i = 0; i < DATA_BITS; i++) add_bits(b[i], 16);
        if (PB == 1) begin
            p = ^b;
            if (!par_good) p = ~p;
            add_bits(p, 16);
        end
        add_bits(stop_v, 16);
    endtask

    task automatic add_cp(input logic [7:0] d, input int rdy, input int ferr, input int perr, input logic bsy);
        cp_t c;
        c.k = line_q.size() - 1;
        c.d = d; c.rdy = rdy; c.ferr = ferr; c.perr = perr; c.bsy = bsy;
        cps.push_back(c);
    endtask

    // ---------------- behavioural receiver ----------------
    function automatic logic maj3(input int j);
        int s;
        s = int'(line_q[j]) + int'(line_q[j+1]) + int'(line_q[j+2]);
        return (s >= 2);
    endfunction

    task automatic mark_busy(input int a, input int z);
        for (int k = a; k <= z; k++) exp_busy[k] = 1'b1;
    endtask

    task automatic compute_model();
        int n;
        int i;
        int sidx;
        int t;
        logic [7:0] b;
        logic pb;
        logic [7:0] d;
        n = line_q.size();
        if (n > MAXN) begin
            $display("[TB] FAIL line_length: got %0d, required at most %0d", n, MAXN);
            $fatal(1, "[TB] stimulus too long");
        end
        for (int k = 0; k < n; k++) begin
            exp_rdy[k] = 1'b0; exp_ferr[k] = 1'b0; exp_perr[k] = 1'b0;
            exp_busy[k] = 1'b0; byte_at[k] = 8'd0;
        end
        i = 0;
        while (i < n) begin
            if (line_q[i]) begin
                i++;
                continue;
            end
            // first low sample at tick i; start votes at i+8..i+10
            if (i + 10 >= n) begin
                mark_busy(i, n - 1);
                break;
            end
            if (maj3(i + 8)) begin
                mark_busy(i, i + 9);
                i = i + 11;
                continue;
            end
            // bit b is voted at i+24+16b..i+26+16b; stop resolved at sidx
            sidx = i + 26 + 16 * (DATA_BITS + PB);
            if (sidx >= n) begin
                mark_busy(i, n - 1);
                break;
            end
            b = 8'd0;
            for (int bi = 0; bi < DATA_BITS; bi++) b[bi] = maj3(i + 24 + 16 * bi);
            pb = 1'b0;
            if (PB == 1) pb = maj3(i + 24 + 16 * DATA_BITS);
            mark_busy(i, sidx - 1);
            if (maj3(sidx - 2)) begin
                exp_rdy[sidx]  = 1'b1;
                byte_at[sidx]  = b;
                exp_perr[sidx] = (PB == 1) && ((^b ^ pb) != 1'b0);
                i = sidx + 1;
            end else begin
                exp_ferr[sidx] = 1'b1;
                t = sidx + 1;
                while (t < n && !line_q[t]) t++;
                mark_busy(sidx, (t < n) ? t - 1 : n - 1);
                i = t + 1;
            end
        end
        d = 8'd0;
        for (int k = 0; k < n; k++) begin
            if (exp_rdy[k]) d = byte_at[k];
            exp_dout[k] = d;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare_proc
        logic       fresh;
        logic       e_rdy;
        logic       e_ferr;
        logic       e_perr;
        logic       e_busy;
        logic [7:0] e_dout;
        if (checking) begin
            if (cur_k < 0) begin
                e_rdy = 1'b0; e_ferr = 1'b0; e_perr = 1'b0; e_busy = 1'b0; e_dout = 8'd0;
            end else begin
                fresh  = (cur_k != seen_k);
                e_rdy  = fresh ? exp_rdy[cur_k]  : 1'b0;
                e_ferr = fresh ? exp_ferr[cur_k] : 1'b0;
                e_perr = fresh ? exp_perr[cur_k] : 1'b0;
                e_busy = exp_busy[cur_k];
                e_dout = exp_dout[cur_k];
            end
            seen_k = cur_k;
            checkOutput("rx_rdy", 32'(rx_rdy), 32'(e_rdy));
            checkOutput("frame_err", 32'(frame_err), 32'(e_ferr));
            checkOutput("par_err", 32'(par_err_w), 32'(e_perr));
            checkOutput("busy", 32'(busy), 32'(e_busy));
            checkOutput("dout", 32'(dout), 32'(e_dout));
            rdy_total  += int'(rx_rdy === 1'b1);
            ferr_total += int'(frame_err === 1'b1);
            perr_total += int'(par_err_w === 1'b1);
        end
    end

    // ---------------- driver ----------------
    task automatic applyStimulus(input int k);
        rxd = line_q[k];
        repeat ($urandom_range(2, 4)) @(posedge clk);
        #1;
        tick16 = 1'b1;
        @(posedge clk);
        #1;
        tick16 = 1'b0;
        cur_k  = k;
    endtask

    task automatic run_line();
        int n;
        int rdy_base;
        int ferr_base;
        int perr_base;
        rst = 1'b1; rxd = 1'b1; tick16 = 1'b0;
        @(posedge clk);
        #1;
        cur_k    = -1;
        checking = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_base  = rdy_total;
        ferr_base = ferr_total;
        perr_base = perr_total;
        compute_model();
        n = line_q.size();
        for (int k = 0; k < n; k++) begin
            applyStimulus(k);
            while (cps.size() > 0 && cps[0].k == k) begin
                @(negedge clk);
                #1;
                checkOutput("cp_dout", 32'(dout), 32'(cps[0].d));
                checkOutput("cp_rdy_count", 32'(rdy_total - rdy_base), 32'(cps[0].rdy));
                checkOutput("cp_ferr_count", 32'(ferr_total - ferr_base), 32'(cps[0].ferr));
                checkOutput("cp_perr_count", 32'(perr_total - perr_base), 32'(cps[0].perr));
                checkOutput("cp_busy", 32'(busy), 32'(cps[0].bsy));
                void'(cps.pop_front());
            end
        end
        cps.delete();
        line_q.delete();
    endtask

    initial begin
        int f;
        int gap;
        int j;
        rst = 1'b1; rxd = 1'b1; tick16 = 1'b0;

        // Run A: directed frames on one continuous line.
        add_bits(1'b1, 5);
        add_cp(8'h00, 0, 0, 0, 1'b0);
        add_frame(8'hA5, 1'b1, 1'b1);
        add_bits(1'b1, 20);
        add_cp(8'hA5, 1, 0, 0, 1'b0);
        add_bits(1'b0, 4);
        add_bits(1'b1, 30);
        add_cp(8'hA5, 1, 0, 0, 1'b0);
        add_frame(8'h3C, 1'b0, 1'b1);
        add_bits(1'b1, 20);
        add_cp(8'hA5, 1, 1, 0, 1'b0);
        add_frame(8'h00, 1'b1, 1'b1);
        add_frame(8'hFF, 1'b1, 1'b1);
        add_bits(1'b1, 20);
        add_cp(8'hFF, 3, 1, 0, 1'b0);
        f = line_q.size();
        add_frame(8'h55, 1'b1, 1'b1);
        line_q[f + 73] = ~line_q[f + 73];
        add_bits(1'b1, 20);
        add_cp(8'h55, 4, 1, 0, 1'b0);
        run_line();

        // Run B: reset lands in the middle of the data bits.
        add_bits(1'b1, 5);
        add_bits(1'b0, 16);
        add_bits(1'b1, 16);
        add_bits(1'b0, 16);
        add_bits(1'b1, 10);
        add_cp(8'h00, 0, 0, 0, 1'b1);
        run_line();

        // Run C: first frame after the aborted one.
        add_bits(1'b1, 5);
        add_cp(8'h00, 0, 0, 0, 1'b0);
        add_frame(8'h81, 1'b1, 1'b1);
        add_bits(1'b1, 20);
        add_cp(8'h81, 1, 0, 0, 1'b0);
        run_line();

`ifdef UART_RX_PARITY_EN
        // Run P: wrong even-parity bit still delivers the byte.
        add_bits(1'b1, 5);
        add_frame(8'h07, 1'b1, 1'b0);
        add_bits(1'b1, 20);
        add_cp(8'h07, 1, 0, 1, 1'b0);
        run_line();
`endif

        // Run R: random frames, gaps, glitches and single-sample noise.
        for (int fr = 0; fr < 25; fr++) begin
            if ($urandom_range(0, 9) == 0) begin
                add_bits(1'b0, $urandom_range(1, 8));
                add_bits(1'b1, 12);
            end
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
            add_bits(1'b1, gap);
            f = line_q.size();
            add_frame(8'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 2) == 0) begin
                j = f + $urandom_range(16, line_q.size() - f - 1);
                line_q[j] = ~line_q[j];
            end
        end
        add_bits(1'b1, 30);
        run_line();

        repeat (3) @(posedge clk);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
